// File: rtl/muldiv_pkg.sv
// Shared types, constants and opcode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on entry, conditional negation
// and high/low/quotient/remainder selection on exit.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  muldiv_op_e        op_in,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_a,
    output logic              neg_b,
    input  muldiv_op_e        op_out,
    input  logic [2*XLEN-1:0] acc,
    input  logic              neg_res,
    input  logic              neg_rem,
    output logic [XLEN-1:0]   fixed
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        neg_a = op_signed_a(op_in) & rs1_val[XLEN-1];
        neg_b = op_signed_b(op_in) & rs2_val[XLEN-1];
        mag_a = neg_a ? -rs1_val : rs1_val;
        mag_b = neg_b ? -rs2_val : rs2_val;
    end

    // The accumulator holds either a full product or {remainder, quotient}.
    always_comb begin
        prod = neg_res ? -acc : acc;
        quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        unique case (op_out)
            OP_MUL:                       fixed = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixed = quot;
            default:                      fixed = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one shift-add or restoring-divide step per cycle,
// with divide-by-zero and signed overflow resolved without iterating.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    muldiv_op_e        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    muldiv_op_e        op_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              in_neg_a, in_neg_b;
    logic [XLEN-1:0]   fixed;
    logic              div_by_zero, div_ovf;

    logic [XLEN:0]     mul_sum;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] acc_step;

    assign op_in = muldiv_op_e'(funct3);

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .op_in   (op_in),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .neg_a   (in_neg_a),
        .neg_b   (in_neg_b),
        .op_out  (op_q),
        .acc     (acc_step),
        .neg_res (neg_res_q),
        .neg_rem (neg_rem_q),
        .fixed   (fixed)
    );

    always_comb begin
        div_by_zero = op_is_div(op_in) && (rs2_val == '0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                      (rs1_val == INT_MIN) && (rs2_val == '1);
    end

    // Multiply keeps the multiplier in the low half and shifts the sum in from the top;
    // divide keeps {remainder, dividend/quotient} and shifts left one bit per step.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_ge  = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
        div_sub = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
        if (op_is_div(op_q)) begin
            if (div_ge) begin
                acc_step = {div_sub, acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        pend_d    = pend_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d      = op_in;
                    rd_d      = rd_in;
                    cnt_d     = '0;
                    neg_res_d = in_neg_a ^ in_neg_b;
                    neg_rem_d = in_neg_a;
                    if (div_by_zero) begin
                        pend_d  = op_is_rem(op_in) ? rs1_val : DIV_ZERO_Q;
                        state_d = FINISH;
                    end else if (div_ovf) begin
                        pend_d  = op_is_rem(op_in) ? '0 : INT_MIN;
                        state_d = FINISH;
                    end else begin
                        opnd_d  = op_is_div(op_in) ? mag_b : mag_a;
                        acc_d   = op_is_div(op_in) ? {{XLEN{1'b0}}, mag_a}
                                                   : {{XLEN{1'b0}}, mag_b};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        pend_d  = fixed;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!kill) begin
                    result_d = pend_q;
                    rd_out_d = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            pend_q    <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    // A kill during FINISH must suppress the write pulse and leave the old write-back visible.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == FINISH) && !kill;
        result = done ? pend_q : result_q;
        rd_out = done ? rd_q : rd_out_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] want;
        int          lat;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    int          got_lat;
    int          got_busy;
    int          dones;
    int          first_at;
    logic [31:0] r1;
    logic [4:0]  rd1;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .STEPS(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .rd_out  (rd_out),
        .result  (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'b000, 3'b001: p = 64'(sa * sb);
            3'b010:         p = 64'(sa * ub);
            3'b011:         p = {32'd0, a} * {32'd0, b};
            default:        p = '0;
        endcase
        case (f)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int nbusy);
        bit seen;
        @(negedge clk);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat   = 0;
        nbusy = 0;
        res   = '0;
        rdo   = '0;
        seen  = 1'b0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
                res  = result;
                rdo  = rd_out;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 33};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 33};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'h7FFF_FFFC, 33};
        vecs[7]  = '{3'b101, 32'h0000_000A, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 1};
        vecs[8]  = '{3'b110, 32'h0000_000A, 32'h0000_0000, 5'd9,  32'h0000_000A, 1};
        vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1};
        vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1};
        vecs[11] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 5'd12, 32'h0000_0002, 33};
        vecs[12] = '{3'b000, 32'h0000_1234, 32'h0000_0010, 5'd0,  32'h0001_2340, 33};

        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        check("reset_result", result, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, got_res, got_rd, got_lat, got_busy);
            check($sformatf("vec%0d_result", i), got_res, vecs[i].want);
            check($sformatf("vec%0d_rd", i), 32'(got_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_latency", i), 32'(got_lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(got_busy), 32'(vecs[i].lat));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_idle_after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_result_hold", i), result, vecs[i].want);
        end

        // Start held high across a MUL, then retargeted to a second op.
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'h7; rs2_val = 32'hFFFF_FFFD; rd_in = 5'd5; start = 1'b1;
        @(posedge clk);
        dones = 0; first_at = 0; r1 = '0; rd1 = '0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                first_at = c;
                r1  = result;
                rd1 = rd_out;
            end
        end
        check("held_done_count", 32'(dones), 32'd1);
        check("held_done_cycle", 32'(first_at), 32'd33);
        check("held_result", r1, 32'hFFFF_FFEB);
        check("held_rd", 32'(rd1), 32'd5);
        funct3 = 3'b011; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_in = 5'd6;
        @(negedge clk);
        check("held_idle_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_second_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        first_at = 0; r1 = '0; rd1 = '0;
        for (int c = 1; c <= 40 && first_at == 0; c++) begin
            @(negedge clk);
            if (done) begin
                first_at = c;
                r1  = result;
                rd1 = rd_out;
            end
        end
        check("second_done_cycle", 32'(first_at), 32'd32);
        check("second_result", r1, 32'hFFFF_FFFE);
        check("second_rd", 32'(rd1), 32'd6);

        // Known write-back, then kill a DIV at T+10.
        run_op(3'b000, 32'h7, 32'hFFFF_FFFD, 5'd5, got_res, got_rd, got_lat, got_busy);
        check("pre_kill_result", got_res, 32'hFFFF_FFEB);
        @(negedge clk);
        funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_low", 32'(busy), 32'd0);
        check("kill_done_low", 32'(done), 32'd0);
        check("kill_result_kept", result, 32'hFFFF_FFEB);
        check("kill_rd_kept", 32'(rd_out), 32'd5);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("kill_no_done", 32'(dones), 32'd0);

        // kill together with start in IDLE: nothing accepted.
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd2; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("idle_kill_start_ignored", 32'(busy), 32'd0);

        // kill during FINISH of a fast-path op suppresses the write.
        @(negedge clk);
        funct3 = 3'b101; rs1_val = 32'd10; rs2_val = 32'd0; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b1;
        @(negedge clk);
        check("finish_kill_busy", 32'(busy), 32'd1);
        check("finish_kill_done", 32'(done), 32'd0);
        check("finish_kill_result", result, 32'hFFFF_FFEB);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("finish_kill_idle", 32'(busy), 32'd0);
        check("finish_kill_rd", 32'(rd_out), 32'd5);

        // Reset in the middle of CALC.
        @(negedge clk);
        funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        check("mid_calc_busy", 32'(busy), 32'd1);
        rst = 1'b1; kill = 1'b1;
        @(negedge clk);
        rst = 1'b0; kill = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_result", result, 32'd0);

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                3:       ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom_range(0, 31));
            run_op(rf, ra, rb, rrd, got_res, got_rd, got_lat, got_busy);
            check($sformatf("rand%0d_f%0d_a%08h_b%08h_result", i, rf, ra, rb), got_res,
                  ref_result(rf, ra, rb));
            check($sformatf("rand%0d_rd", i), 32'(got_rd), 32'(rrd));
            check($sformatf("rand%0d_latency", i), 32'(got_lat), 32'(ref_lat(rf, ra, rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Consumes the two register-file read operands and produces the write-back data, destination address and write-enable pulse for the register file's write port.
- Sits between register read and write-back. It stalls the core through busy while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- STEPS, 32, iteration count per operation; must equal XLEN.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- kill  input  1  synchronous abort of the in-flight operation (pipeline flush)
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  32  operand A (register-file read port 1)
- rs2_val  input  32  operand B (register-file read port 2)
- rd_in  input  5  destination register
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle result-valid pulse; drives register-file write enable
- rd_out  output  5  destination; drives register-file write address
- result  output  32  write-back data

Behaviour:
- Reset: state=IDLE, busy=0, done=0, rd_out=0, result=0, counter=0, all datapath registers 0. Reset has priority over everything, including mid-operation.
- States: IDLE, CALC, FINISH.
- IDLE -> CALC:
  - Taken on start=1.
  - Latch funct3, rd_in, and the sign flags sa, sb per op. Signed for MUL/MULH/DIV/REM; MULHSU is signed A, unsigned B; MULU/DIVU/REMU are unsigned.
  - Latch magnitudes |A|, |B| and clear counter.
- IDLE -> FINISH (fast path, no CALC):
  - Divide by zero (rs2_val=0, ops 1xx): quotient = 0xFFFFFFFF, remainder = rs1_val.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC:
  - One iteration per cycle; counter 0..31; go to FINISH after the cycle with counter=31.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial-remainder subtract.
- Entering FINISH, apply sign fix:
  - Product is negated if sa^sb.
  - Quotient is negated if sa^sb.
  - Remainder is negated if sa.
  - MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
- FINISH: done=1, result and rd_out valid for exactly this cycle; then -> IDLE.
- result and rd_out hold their values after done falls until the next FINISH.
- Latency: start sampled at cycle T.
  - Normal path: done at T+33; busy high T+1..T+33.
  - Fast path: done at T+1; busy high T+1 only.
  - Earliest next accepted start: cycle after done.
- start while busy: ignored, not queued.
- rd_in=0: done still pulses; the register file discards x0 writes.
- kill:
  - In CALC or FINISH: next state IDLE, done forced 0 that cycle, result/rd_out unchanged.
  - In IDLE: no effect, and start in the same cycle is not accepted.
- rst and kill together: rst wins; outputs take reset values.

Decomposition:
- Shared package muldiv_pkg holds:
  - enum muldiv_op_e for the funct3 codes;
  - enum muldiv_state_e {IDLE, CALC, FINISH};
  - localparams DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module is natural: muldiv_signfix. It is combinational: magnitude extraction on entry and conditional negation/select on exit.
- The FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MUL 7 x -3 (rs1=0x00000007, rs2=0xFFFFFFFD, rd=5) -> done at T+33, result=0xFFFFFFEB, rd_out=5; busy high exactly 33 cycles.
- MULH/MULHSU/MULHU with A=B=0xFFFFFFFF -> results 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE respectively.
- DIV -7/2 and REM -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIVU 10/0 -> done at T+1 with 0xFFFFFFFF; REM 10/0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at T+1.
- start held high throughout a MUL -> exactly one done; second op accepted only on the cycle after done, and its result is correct.
- kill at T+10 of a DIV -> no done pulse, busy low at T+11, result unchanged; rst asserted mid-CALC -> all outputs 0 next cycle.
